// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: widths, opcode constants, NOP encoding and the
// fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_I      = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_AUIPC  = 7'd23;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: redirect mux with bit0 clear, sequential +4 adder and
// misaligned-target detection.
module next_pc_sel #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic [XLEN-1:0] i_instr_pc,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_misalign
);

    localparam logic [XLEN-1:0] CLR_BIT0 = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] w_target;

    // JALR targets may carry bit0 set; the architecture discards it
    assign w_target   = i_redirect_pc & CLR_BIT0;
    assign o_pc_plus4 = i_instr_pc + XLEN'(4);
    assign o_next_pc  = i_redirect_valid ? w_target : o_pc_plus4;
    assign o_misalign = i_redirect_valid & w_target[1];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per step over a
// req/gnt/rvalid handshake and presents a registered instruction to decode.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [31:0]     o_instr,
    output logic [6:0]      o_opcode,
    output logic [XLEN-1:0] o_instr_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_instr_valid,
    output logic            o_misalign_err
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_d;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_d;
    logic            r_req;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] w_addr_d;
    logic [31:0]     r_instr;
    logic [31:0]     w_instr_d;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] w_instr_pc_d;
    logic            r_instr_valid;
    logic            r_misalign;
    logic            w_misalign_d;

    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_misalign;

    next_pc_sel #(
        .XLEN (XLEN)
    ) u_next_pc_sel (
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_instr_pc       (r_instr_pc),
        .o_next_pc        (w_next_pc),
        .o_pc_plus4       (w_pc_plus4),
        .o_misalign       (w_misalign)
    );

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_addr_d     = r_addr;
        w_instr_d    = r_instr;
        w_instr_pc_d = r_instr_pc;
        w_misalign_d = r_misalign;
        unique case (r_state)
            IDLE: begin
                w_state_d = REQ;
                w_addr_d  = r_pc;
            end
            REQ: begin
                if (i_imem_gnt) begin
                    w_state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_imem_rvalid) begin
                    w_instr_d    = i_imem_rdata;
                    w_instr_pc_d = r_pc;
                    w_state_d    = VALID;
                end
            end
            VALID: begin
                // Redirects only take effect when decode accepts the instruction
                if (!i_stall) begin
                    if (w_misalign) begin
                        w_misalign_d = 1'b1;
                        w_state_d    = HALT;
                    end else begin
                        w_pc_d    = w_next_pc;
                        w_addr_d  = w_next_pc;
                        w_state_d = REQ;
                    end
                end
            end
            HALT: begin
                w_state_d = HALT;
            end
            default: begin
                w_state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_req         <= 1'b0;
            r_addr        <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            // Handshake outputs are registered from the next state
            r_req         <= (w_state_d == REQ);
            r_addr        <= w_addr_d;
            r_instr       <= w_instr_d;
            r_instr_pc    <= w_instr_pc_d;
            r_instr_valid <= (w_state_d == VALID);
            r_misalign    <= w_misalign_d;
        end
    end

    assign o_imem_req     = r_req;
    assign o_imem_addr    = r_addr;
    assign o_instr        = r_instr;
    assign o_opcode       = r_instr[6:0];
    assign o_instr_pc     = r_instr_pc;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_instr_valid  = r_instr_valid;
    assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a small imem responder
// whose grant delay and response can be steered by the stimulus.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign_err;

    int          checks = 0;
    int          errors = 0;
    int          gnt_delay = 0;
    bit          hold_rvalid = 0;
    int          gnt_cnt = 0;
    logic [31:0] gnt_addr = '0;
    logic [31:0] fetch_log[$];
    int          n_fetch;

    instr_fetch_unit dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_gnt       (imem_gnt),
        .i_imem_rvalid    (imem_rvalid),
        .i_imem_rdata     (imem_rdata),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_instr          (instr),
        .o_opcode         (opcode),
        .o_instr_pc       (instr_pc),
        .o_pc_plus4       (pc_plus4),
        .o_instr_valid    (instr_valid),
        .o_misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[24:0], 7'd51};
    endfunction

    // imem model, acts on the falling edge so the DUT samples stable inputs
    always @(negedge clk) begin
        if (reset) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            gnt_cnt     = 0;
        end else if (imem_gnt) begin
            imem_gnt = 1'b0;
            if (!hold_rvalid) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(gnt_addr);
            end
        end else begin
            imem_rvalid = 1'b0;
            if (imem_req) begin
                if (gnt_cnt >= gnt_delay) begin
                    imem_gnt = 1'b1;
                    gnt_addr = imem_addr;
                    fetch_log.push_back(imem_addr);
                    gnt_cnt  = 0;
                end else begin
                    gnt_cnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc, input int budget);
        int n = 0;
        while (!(instr_valid === 1'b1 && instr_pc === pc) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'b0, instr_valid}, 32'h1);
        chk("wait_pc", instr_pc, pc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_opcode"}, {25'b0, opcode}, 32'd19);
        chk({tag, "_ipc"}, instr_pc, 32'h0);
        chk({tag, "_pc4"}, pc_plus4, 32'h4);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, "_mis"}, {31'b0, misalign_err}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;

        // Reset values and first fetch
        #2;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("idle_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        wait_valid_pc(32'h0, 10);
        chk("first_opcode", {25'b0, opcode}, 32'd19);
        chk("first_instr", instr, 32'h0050_0093);

        // Grant held off for three cycles on the fetch of 0x4
        gnt_delay = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req", {31'b0, imem_req}, 32'h1);
            chk("hold_addr", imem_addr, 32'h4);
        end
        gnt_delay = 0;
        tick();
        chk("wait_req", {31'b0, imem_req}, 32'h0);
        chk("wait_valid0", {31'b0, instr_valid}, 32'h0);
        tick();
        chk("single_wait_valid", {31'b0, instr_valid}, 32'h1);
        chk("single_wait_pc", instr_pc, 32'h4);
        chk("instr_4", instr, 32'h0000_0233);

        // Sequential stream
        wait_valid_pc(32'h8, 10);
        chk("pc_plus4_3rd", pc_plus4, 32'hC);
        wait_valid_pc(32'hC, 10);
        chk("log0", fetch_log[0], 32'h0);
        chk("log1", fetch_log[1], 32'h4);
        chk("log2", fetch_log[2], 32'h8);
        chk("log3", fetch_log[3], 32'hC);

        // Stall with a pending redirect at 0x10
        tick();
        stall = 1'b1;
        wait_valid_pc(32'h10, 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        n_fetch        = fetch_log.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
            chk("stall_req", {31'b0, imem_req}, 32'h0);
        end
        chk("stall_ipc", instr_pc, 32'h10);
        chk("stall_nofetch", fetch_log.size(), n_fetch);
        stall = 1'b0;
        tick();
        redirect_valid = 1'b0;
        chk("redir_req", {31'b0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h100);
        wait_valid_pc(32'h100, 10);

        // JALR with bit0 set, then a misaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h201;
        tick();
        redirect_valid = 1'b0;
        chk("jalr_addr", imem_addr, 32'h200);
        wait_valid_pc(32'h200, 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        n_fetch        = fetch_log.size();
        tick();
        redirect_valid = 1'b0;
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        chk("mis_valid", {31'b0, instr_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_req", {31'b0, imem_req}, 32'h0);
        end
        chk("halt_sticky", {31'b0, misalign_err}, 32'h1);
        chk("halt_nofetch", fetch_log.size(), n_fetch);

        // Fresh run up to 0x40, then reset while waiting for the response
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst2");
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_valid_pc(32'h40, 300);
        hold_rvalid = 1'b1;
        tick();
        chk("pre_wait_addr", imem_addr, 32'h44);
        tick();
        chk("in_wait_req", {31'b0, imem_req}, 32'h0);
        chk("in_wait_valid", {31'b0, instr_valid}, 32'h0);
        chk("in_wait_ipc", instr_pc, 32'h40);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst_wait");
        hold_rvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        wait_valid_pc(32'h0, 10);

        // Sequential wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid_pc(32'hFFFF_FFFC, 10);
        chk("wrap_pc4", pc_plus4, 32'h0);
        tick();
        chk("wrap_req", {31'b0, imem_req}, 32'h1);
        chk("wrap_addr", imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
